// File: rtl/rob_pkg.sv
// Shared reorder-buffer definitions: entry type codes, the "no dependency" tag
// used by the dispatcher and reservation station, and a pc helper.
package rob_pkg;

    typedef enum logic [1:0] {
        ROB_REG    = 2'd0,
        ROB_BRANCH = 2'd1,
        ROB_JALR   = 2'd2,
        ROB_STORE  = 2'd3
    } rob_type_e;

    localparam int ROB_DEFAULT_WIDTH = 3;
    localparam int ROB_NON_DEP       = 1 << ROB_DEFAULT_WIDTH;

    function automatic logic [31:0] rob_next_pc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/rob_query_port.sv
// One operand lookup into the reorder buffer. Build option ROB_BYPASS_EN adds a
// same-cycle match against the RS and LSB result broadcasts (LSB has priority).
module rob_query_port
    import rob_pkg::*;
#(
    parameter int IDX_W   = 3,
    parameter int ENTRIES = 8
) (
    input  logic [IDX_W-1:0]          index_i,
    input  logic [ENTRIES-1:0]        busy_i,
    input  logic [ENTRIES-1:0]        ready_i,
    input  logic [ENTRIES-1:0][31:0]  data_i,
    input  logic                      rs_en_i,
    input  logic [IDX_W-1:0]          rs_index_i,
    input  logic [31:0]               rs_data_i,
    input  logic                      lsb_en_i,
    input  logic [IDX_W-1:0]          lsb_index_i,
    input  logic [31:0]               lsb_data_i,
    output logic                      ready_o,
    output logic [31:0]               data_o
);

`ifdef ROB_BYPASS_EN
    always_comb begin
        ready_o = busy_i[index_i] && ready_i[index_i];
        data_o  = data_i[index_i];
        // Only a live entry can accept a broadcast, so bypass obeys the same rule.
        if (busy_i[index_i]) begin
            if (lsb_en_i && (lsb_index_i == index_i)) begin
                ready_o = 1'b1;
                data_o  = lsb_data_i;
            end else if (rs_en_i && (rs_index_i == index_i)) begin
                ready_o = 1'b1;
                data_o  = rs_data_i;
            end
        end
    end
`else
    assign ready_o = busy_i[index_i] && ready_i[index_i];
    assign data_o  = data_i[index_i];

    logic unused_bypass;
    assign unused_bypass = ^{rs_en_i, rs_index_i, rs_data_i, lsb_en_i, lsb_index_i, lsb_data_i};
`endif

endmodule

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: in-order retirement, branch/jalr redirect via a full
// backend flush, and two operand lookup ports (bypass selected by ROB_BYPASS_EN).
module reorder_buffer
    import rob_pkg::*;
#(
    parameter int RoB_WIDTH = 3,
    parameter int RoB_SIZE  = 1 << RoB_WIDTH,
    parameter int NON_DEP   = 1 << RoB_WIDTH
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 alloc_en,
    input  logic [1:0]           alloc_type,
    input  logic [4:0]           alloc_rd,
    input  logic [31:0]          alloc_pc,
    input  logic                 alloc_pred_taken,
    input  logic [31:0]          alloc_target,
    output logic [RoB_WIDTH-1:0] alloc_robEntry,
    input  logic                 RS_update_en,
    input  logic [RoB_WIDTH-1:0] RS_update_index,
    input  logic [31:0]          RS_update_data,
    input  logic                 LSB_update_en,
    input  logic [RoB_WIDTH-1:0] LSB_update_index,
    input  logic [31:0]          LSB_update_data,
    input  logic [RoB_WIDTH-1:0] query_j_index,
    input  logic [RoB_WIDTH-1:0] query_k_index,
    output logic                 query_j_ready,
    output logic [31:0]          query_j_data,
    output logic                 query_k_ready,
    output logic [31:0]          query_k_data,
    output logic                 commit_en,
    output logic [4:0]           commit_rd,
    output logic [31:0]          commit_data,
    output logic [RoB_WIDTH-1:0] commit_robEntry,
    output logic                 commit_store_en,
    output logic [RoB_WIDTH-1:0] commit_store_robEntry,
    output logic                 flush_signal,
    output logic [31:0]          flush_pc,
    output logic                 isFull,
    output logic                 isEmpty
);

    localparam int CW = RoB_WIDTH + 1;

    logic [RoB_WIDTH-1:0]       head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]              count_q, count_d;
    logic [RoB_SIZE-1:0]        busy_q, ready_q, pred_q;
    logic [RoB_SIZE-1:0][31:0]  data_q;
    rob_type_e                  type_q   [RoB_SIZE];
    logic [4:0]                 rd_q     [RoB_SIZE];
    logic [31:0]                pc_q     [RoB_SIZE];
    logic [31:0]                target_q [RoB_SIZE];

    logic                 commit_en_q, store_en_q, flush_q;
    logic [4:0]           commit_rd_q;
    logic [31:0]          commit_data_q, flush_pc_q;
    logic [RoB_WIDTH-1:0] commit_entry_q, store_entry_q;

    logic alloc_ok, commit_ok;

    assign isFull         = (count_q == CW'(RoB_SIZE));
    assign isEmpty        = (count_q == '0);
    assign alloc_robEntry = tail_q;

    always_comb begin
        alloc_ok  = alloc_en && !isFull;
        commit_ok = busy_q[head_q] && ready_q[head_q];
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        if (flush_q) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (commit_ok) head_d = head_q + RoB_WIDTH'(1);
            if (alloc_ok)  tail_d = tail_q + RoB_WIDTH'(1);
            count_d = count_q + CW'(alloc_ok) - CW'(commit_ok);
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            busy_q         <= '0;
            ready_q        <= '0;
            pred_q         <= '0;
            data_q         <= '0;
            for (int i = 0; i < RoB_SIZE; i++) begin
                type_q[i]   <= ROB_REG;
                rd_q[i]     <= '0;
                pc_q[i]     <= '0;
                target_q[i] <= '0;
            end
            commit_en_q    <= 1'b0;
            commit_rd_q    <= '0;
            commit_data_q  <= '0;
            commit_entry_q <= '0;
            store_en_q     <= 1'b0;
            store_entry_q  <= '0;
            flush_q        <= 1'b0;
            flush_pc_q     <= '0;
        end else if (rdy_in) begin
            commit_en_q <= 1'b0;
            store_en_q  <= 1'b0;
            flush_q     <= 1'b0;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            if (flush_q) begin
                // Redirect cycle: everything in flight belongs to the wrong path.
                busy_q  <= '0;
                ready_q <= '0;
            end else begin
                if (RS_update_en && busy_q[RS_update_index]) begin
                    ready_q[RS_update_index] <= 1'b1;
                    data_q[RS_update_index]  <= RS_update_data;
                end
                if (LSB_update_en && busy_q[LSB_update_index]) begin
                    ready_q[LSB_update_index] <= 1'b1;
                    data_q[LSB_update_index]  <= LSB_update_data;
                end
                if (commit_ok) begin
                    busy_q[head_q]  <= 1'b0;
                    ready_q[head_q] <= 1'b0;
                    case (type_q[head_q])
                        ROB_REG: begin
                            commit_en_q    <= 1'b1;
                            commit_rd_q    <= rd_q[head_q];
                            commit_data_q  <= data_q[head_q];
                            commit_entry_q <= head_q;
                        end
                        ROB_STORE: begin
                            store_en_q    <= 1'b1;
                            store_entry_q <= head_q;
                        end
                        ROB_BRANCH: begin
                            if (data_q[head_q][0] != pred_q[head_q]) begin
                                flush_q    <= 1'b1;
                                flush_pc_q <= data_q[head_q][0] ? target_q[head_q]
                                                                : rob_next_pc(pc_q[head_q]);
                            end
                        end
                        ROB_JALR: begin
                            commit_en_q    <= 1'b1;
                            commit_rd_q    <= rd_q[head_q];
                            commit_data_q  <= rob_next_pc(pc_q[head_q]);
                            commit_entry_q <= head_q;
                            flush_q        <= 1'b1;
                            flush_pc_q     <= data_q[head_q];
                        end
                        default: ;
                    endcase
                end
                if (alloc_ok) begin
                    busy_q[tail_q]   <= 1'b1;
                    ready_q[tail_q]  <= 1'b0;
                    type_q[tail_q]   <= rob_type_e'(alloc_type);
                    rd_q[tail_q]     <= alloc_rd;
                    pc_q[tail_q]     <= alloc_pc;
                    pred_q[tail_q]   <= alloc_pred_taken;
                    target_q[tail_q] <= alloc_target;
                end
            end
        end
    end

    assign commit_en             = commit_en_q;
    assign commit_rd             = commit_rd_q;
    assign commit_data           = commit_data_q;
    assign commit_robEntry       = commit_entry_q;
    assign commit_store_en       = store_en_q;
    assign commit_store_robEntry = store_entry_q;
    assign flush_signal          = flush_q;
    assign flush_pc              = flush_pc_q;

    // A tag equal to NON_DEP never reports ready, even if it aliases a real slot.
    logic j_raw_ready, k_raw_ready, j_tag_valid, k_tag_valid;
    assign j_tag_valid   = ({1'b0, query_j_index} != CW'(NON_DEP));
    assign k_tag_valid   = ({1'b0, query_k_index} != CW'(NON_DEP));
    assign query_j_ready = j_raw_ready && j_tag_valid;
    assign query_k_ready = k_raw_ready && k_tag_valid;

    rob_query_port #(.IDX_W(RoB_WIDTH), .ENTRIES(RoB_SIZE)) u_query_j (
        .index_i     (query_j_index),
        .busy_i      (busy_q),
        .ready_i     (ready_q),
        .data_i      (data_q),
        .rs_en_i     (RS_update_en),
        .rs_index_i  (RS_update_index),
        .rs_data_i   (RS_update_data),
        .lsb_en_i    (LSB_update_en),
        .lsb_index_i (LSB_update_index),
        .lsb_data_i  (LSB_update_data),
        .ready_o     (j_raw_ready),
        .data_o      (query_j_data)
    );

    rob_query_port #(.IDX_W(RoB_WIDTH), .ENTRIES(RoB_SIZE)) u_query_k (
        .index_i     (query_k_index),
        .busy_i      (busy_q),
        .ready_i     (ready_q),
        .data_i      (data_q),
        .rs_en_i     (RS_update_en),
        .rs_index_i  (RS_update_index),
        .rs_data_i   (RS_update_data),
        .lsb_en_i    (LSB_update_en),
        .lsb_index_i (LSB_update_index),
        .lsb_data_i  (LSB_update_data),
        .ready_o     (k_raw_ready),
        .data_o      (query_k_data)
    );

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: a per-cycle vector table plus hand-written
// sequences for wrap-around, same-index writeback/bypass and reset during flush.
module tb_reorder_buffer;
    import rob_pkg::*;

    localparam logic T = 1'b1;
    localparam logic F = 1'b0;

    logic        clk = 1'b0;
    logic        rst_in, rdy_in;
    logic        alloc_en, alloc_pred_taken;
    logic [1:0]  alloc_type;
    logic [4:0]  alloc_rd;
    logic [31:0] alloc_pc, alloc_target;
    logic [2:0]  alloc_robEntry;
    logic        RS_update_en, LSB_update_en;
    logic [2:0]  RS_update_index, LSB_update_index;
    logic [31:0] RS_update_data, LSB_update_data;
    logic [2:0]  query_j_index, query_k_index;
    logic        query_j_ready, query_k_ready;
    logic [31:0] query_j_data, query_k_data;
    logic        commit_en, commit_store_en, flush_signal, isFull, isEmpty;
    logic [4:0]  commit_rd;
    logic [31:0] commit_data, flush_pc;
    logic [2:0]  commit_robEntry, commit_store_robEntry;

    int n_cmp  = 0;
    int n_fail = 0;

    reorder_buffer dut (
        .clk_in(clk), .rst_in(rst_in), .rdy_in(rdy_in),
        .alloc_en(alloc_en), .alloc_type(alloc_type), .alloc_rd(alloc_rd),
        .alloc_pc(alloc_pc), .alloc_pred_taken(alloc_pred_taken),
        .alloc_target(alloc_target), .alloc_robEntry(alloc_robEntry),
        .RS_update_en(RS_update_en), .RS_update_index(RS_update_index),
        .RS_update_data(RS_update_data),
        .LSB_update_en(LSB_update_en), .LSB_update_index(LSB_update_index),
        .LSB_update_data(LSB_update_data),
        .query_j_index(query_j_index), .query_k_index(query_k_index),
        .query_j_ready(query_j_ready), .query_j_data(query_j_data),
        .query_k_ready(query_k_ready), .query_k_data(query_k_data),
        .commit_en(commit_en), .commit_rd(commit_rd), .commit_data(commit_data),
        .commit_robEntry(commit_robEntry),
        .commit_store_en(commit_store_en), .commit_store_robEntry(commit_store_robEntry),
        .flush_signal(flush_signal), .flush_pc(flush_pc),
        .isFull(isFull), .isEmpty(isEmpty)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic rdy; logic aen; logic [1:0] aty; logic [4:0] ard; logic [31:0] apc;
        logic apred; logic [31:0] atgt;
        logic rse; logic [2:0] rsi; logic [31:0] rsd;
        logic lse; logic [2:0] lsi; logic [31:0] lsd;
        logic ecen; logic [4:0] erd; logic [31:0] edat; logic [2:0] eent;
        logic est; logic efl; logic [31:0] efpc;
        logic eemp; logic efull; logic [2:0] etail;
    } vec_t;

    vec_t vec [24];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rdy_in = 1'b1; alloc_en = 1'b0; alloc_type = 2'd0; alloc_rd = 5'd0;
        alloc_pc = 32'd0; alloc_pred_taken = 1'b0; alloc_target = 32'd0;
        RS_update_en = 1'b0; RS_update_index = 3'd0; RS_update_data = 32'd0;
        LSB_update_en = 1'b0; LSB_update_index = 3'd0; LSB_update_data = 32'd0;
        query_j_index = 3'd0; query_k_index = 3'd0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_in = 1'b1;
        step();
        step();
        rst_in = 1'b0;
    endtask

    task automatic alloc(input logic [1:0] ty, input logic [4:0] rd, input logic [31:0] pc);
        idle_inputs();
        alloc_en = 1'b1; alloc_type = ty; alloc_rd = rd; alloc_pc = pc;
        step();
        idle_inputs();
    endtask

    task automatic apply(input vec_t v, input int idx);
        string s;
        rdy_in = v.rdy; alloc_en = v.aen; alloc_type = v.aty; alloc_rd = v.ard;
        alloc_pc = v.apc; alloc_pred_taken = v.apred; alloc_target = v.atgt;
        RS_update_en = v.rse; RS_update_index = v.rsi; RS_update_data = v.rsd;
        LSB_update_en = v.lse; LSB_update_index = v.lsi; LSB_update_data = v.lsd;
        step();
        s = $sformatf("v%0d", idx);
        chk({s, ".commit_en"}, 32'(commit_en), 32'(v.ecen));
        if (v.ecen) begin
            chk({s, ".commit_rd"}, 32'(commit_rd), 32'(v.erd));
            chk({s, ".commit_data"}, commit_data, v.edat);
            chk({s, ".commit_robEntry"}, 32'(commit_robEntry), 32'(v.eent));
        end
        chk({s, ".commit_store_en"}, 32'(commit_store_en), 32'(v.est));
        if (v.est) chk({s, ".store_robEntry"}, 32'(commit_store_robEntry), 32'(v.eent));
        chk({s, ".flush_signal"}, 32'(flush_signal), 32'(v.efl));
        if (v.efl) chk({s, ".flush_pc"}, flush_pc, v.efpc);
        chk({s, ".isEmpty"}, 32'(isEmpty), 32'(v.eemp));
        chk({s, ".isFull"}, 32'(isFull), 32'(v.efull));
        chk({s, ".alloc_robEntry"}, 32'(alloc_robEntry), 32'(v.etail));
    endtask

    logic [4:0] rd_m [8];
    int         head_m, tail_m;

    initial begin
        // rdy aen type rd pc pred target | RS | LSB | cen rd data ent | st | fl fpc | emp full tail
        vec[0]  = '{T,T,ROB_REG,5'd1,32'h0,F,32'h0,      F,3'd0,32'h0,   F,3'd0,32'h0, F,5'd0,32'h0,3'd0,   F, F,32'h0,   F,F,3'd1};
        vec[1]  = '{T,T,ROB_REG,5'd2,32'h0,F,32'h0,      F,3'd0,32'h0,   F,3'd0,32'h0, F,5'd0,32'h0,3'd0,   F, F,32'h0,   F,F,3'd2};
        vec[2]  = '{T,T,ROB_REG,5'd3,32'h0,F,32'h0,      F,3'd0,32'h0,   F,3'd0,32'h0, F,5'd0,32'h0,3'd0,   F, F,32'h0,   F,F,3'd3};
        vec[3]  = '{T,F,ROB_REG,5'd0,32'h0,F,32'h0,      T,3'd2,32'h30,  F,3'd0,32'h0, F,5'd0,32'h0,3'd0,   F, F,32'h0,   F,F,3'd3};
        vec[4]  = '{T,F,ROB_REG,5'd0,32'h0,F,32'h0,      T,3'd0,32'h10,  F,3'd0,32'h0, F,5'd0,32'h0,3'd0,   F, F,32'h0,   F,F,3'd3};
        vec[5]  = '{T,F,ROB_REG,5'd0,32'h0,F,32'h0,      T,3'd1,32'h20,  F,3'd0,32'h0, T,5'd1,32'h10,3'd0,  F, F,32'h0,   F,F,3'd3};
        vec[6]  = '{T,F,ROB_REG,5'd0,32'h0,F,32'h0,      F,3'd0,32'h0,   F,3'd0,32'h0, T,5'd2,32'h20,3'd1,  F, F,32'h0,   F,F,3'd3};
        vec[7]  = '{T,F,ROB_REG,5'd0,32'h0,F,32'h0,      F,3'd0,32'h0,   F,3'd0,32'h0, T,5'd3,32'h30,3'd2,  F, F,32'h0,   T,F,3'd3};
        vec[8]  = '{T,F,ROB_REG,5'd0,32'h0,F,32'h0,      F,3'd0,32'h0,   F,3'd0,32'h0, F,5'd0,32'h0,3'd0,   F, F,32'h0,   T,F,3'd3};
        vec[9]  = '{F,T,ROB_REG,5'd4,32'h0,F,32'h0,      F,3'd0,32'h0,   F,3'd0,32'h0, F,5'd0,32'h0,3'd0,   F, F,32'h0,   T,F,3'd3};
        vec[10] = '{T,T,ROB_BRANCH,5'd0,32'h40,F,32'h100, F,3'd0,32'h0,  F,3'd0,32'h0, F,5'd0,32'h0,3'd0,   F, F,32'h0,   F,F,3'd4};
        vec[11] = '{T,F,ROB_REG,5'd0,32'h0,F,32'h0,      T,3'd3,32'h1,   F,3'd0,32'h0, F,5'd0,32'h0,3'd0,   F, F,32'h0,   F,F,3'd4};
        vec[12] = '{T,T,ROB_REG,5'd5,32'h0,F,32'h0,      F,3'd0,32'h0,   F,3'd0,32'h0, F,5'd0,32'h0,3'd0,   F, T,32'h100, F,F,3'd5};
        vec[13] = '{T,T,ROB_REG,5'd6,32'h0,F,32'h0,      F,3'd0,32'h0,   F,3'd0,32'h0, F,5'd0,32'h0,3'd0,   F, F,32'h0,   T,F,3'd0};
        vec[14] = '{T,T,ROB_JALR,5'd1,32'h80,F,32'h0,    F,3'd0,32'h0,   F,3'd0,32'h0, F,5'd0,32'h0,3'd0,   F, F,32'h0,   F,F,3'd1};
        vec[15] = '{T,F,ROB_REG,5'd0,32'h0,F,32'h0,      T,3'd0,32'h200, F,3'd0,32'h0, F,5'd0,32'h0,3'd0,   F, F,32'h0,   F,F,3'd1};
        vec[16] = '{T,F,ROB_REG,5'd0,32'h0,F,32'h0,      F,3'd0,32'h0,   F,3'd0,32'h0, T,5'd1,32'h84,3'd0,  F, T,32'h200, T,F,3'd1};
        vec[17] = '{T,F,ROB_REG,5'd0,32'h0,F,32'h0,      F,3'd0,32'h0,   F,3'd0,32'h0, F,5'd0,32'h0,3'd0,   F, F,32'h0,   T,F,3'd0};
        vec[18] = '{T,T,ROB_BRANCH,5'd0,32'h50,T,32'h200, F,3'd0,32'h0,  F,3'd0,32'h0, F,5'd0,32'h0,3'd0,   F, F,32'h0,   F,F,3'd1};
        vec[19] = '{T,F,ROB_REG,5'd0,32'h0,F,32'h0,      F,3'd0,32'h0,   T,3'd0,32'h1, F,5'd0,32'h0,3'd0,   F, F,32'h0,   F,F,3'd1};
        vec[20] = '{T,F,ROB_REG,5'd0,32'h0,F,32'h0,      F,3'd0,32'h0,   F,3'd0,32'h0, F,5'd0,32'h0,3'd0,   F, F,32'h0,   T,F,3'd1};
        vec[21] = '{T,T,ROB_STORE,5'd0,32'h60,F,32'h0,   F,3'd0,32'h0,   F,3'd0,32'h0, F,5'd0,32'h0,3'd0,   F, F,32'h0,   F,F,3'd2};
        vec[22] = '{T,F,ROB_REG,5'd0,32'h0,F,32'h0,      F,3'd0,32'h0,   T,3'd1,32'h5, F,5'd0,32'h0,3'd0,   F, F,32'h0,   F,F,3'd2};
        vec[23] = '{T,F,ROB_REG,5'd0,32'h0,F,32'h0,      F,3'd0,32'h0,   F,3'd0,32'h0, F,5'd0,32'h0,3'd1,   T, F,32'h0,   T,F,3'd2};

        // Reset state
        do_reset();
        chk("rst.commit_en", 32'(commit_en), 32'd0);
        chk("rst.commit_store_en", 32'(commit_store_en), 32'd0);
        chk("rst.flush_signal", 32'(flush_signal), 32'd0);
        chk("rst.commit_rd", 32'(commit_rd), 32'd0);
        chk("rst.commit_data", commit_data, 32'd0);
        chk("rst.flush_pc", flush_pc, 32'd0);
        chk("rst.isEmpty", 32'(isEmpty), 32'd1);
        chk("rst.isFull", 32'(isFull), 32'd0);
        chk("rst.alloc_robEntry", 32'(alloc_robEntry), 32'd0);
        chk("rst.query_j_ready", 32'(query_j_ready), 32'd0);

        for (int i = 0; i < 24; i++) apply(vec[i], i);

        // Fill to full, then alloc alongside a commit: the alloc is dropped
        do_reset();
        for (int i = 0; i < 8; i++) begin
            alloc(ROB_REG, 5'(10 + i), 32'h0);
            rd_m[i] = 5'(10 + i);
        end
        chk("fill.isFull", 32'(isFull), 32'd1);
        chk("fill.alloc_robEntry", 32'(alloc_robEntry), 32'd0);
        RS_update_en = 1'b1; RS_update_index = 3'd0; RS_update_data = 32'h1000;
        step();
        idle_inputs();
        chk("fill.wb_still_full", 32'(isFull), 32'd1);
        alloc_en = 1'b1; alloc_rd = 5'd9;
        step();
        idle_inputs();
        chk("full_alloc.commit_en", 32'(commit_en), 32'd1);
        chk("full_alloc.commit_rd", 32'(commit_rd), 32'd10);
        chk("full_alloc.commit_data", commit_data, 32'h1000);
        chk("full_alloc.isFull", 32'(isFull), 32'd0);
        chk("full_alloc.tail_held", 32'(alloc_robEntry), 32'd0);
        head_m = 1;
        tail_m = 0;
        for (int k = 0; k < 20; k++) begin
            RS_update_en = 1'b1; RS_update_index = 3'(head_m); RS_update_data = 32'h2000 + 32'(k);
            step();
            idle_inputs();
            alloc_en = 1'b1; alloc_rd = 5'(20 + k);
            step();
            idle_inputs();
            chk($sformatf("wrap%0d.commit_en", k), 32'(commit_en), 32'd1);
            chk($sformatf("wrap%0d.commit_robEntry", k), 32'(commit_robEntry), 32'(head_m));
            chk($sformatf("wrap%0d.commit_rd", k), 32'(commit_rd), 32'(rd_m[head_m]));
            chk($sformatf("wrap%0d.commit_data", k), commit_data, 32'h2000 + 32'(k));
            chk($sformatf("wrap%0d.alloc_robEntry", k), 32'(alloc_robEntry), 32'((tail_m + 1) % 8));
            chk($sformatf("wrap%0d.isFull", k), 32'(isFull), 32'd0);
            rd_m[tail_m] = 5'(20 + k);
            head_m = (head_m + 1) % 8;
            tail_m = (tail_m + 1) % 8;
        end

        // Same-index RS and LSB writeback; query in the same cycle and after
        do_reset();
        for (int i = 0; i < 5; i++) alloc(ROB_REG, 5'(1 + i), 32'h0);
        RS_update_en = 1'b1; RS_update_index = 3'd4; RS_update_data = 32'hA;
        LSB_update_en = 1'b1; LSB_update_index = 3'd4; LSB_update_data = 32'hB;
        query_j_index = 3'd4; query_k_index = 3'd3;
        #1;
`ifdef ROB_BYPASS_EN
        chk("byp.j_ready_same_cycle", 32'(query_j_ready), 32'd1);
        chk("byp.j_data_same_cycle", query_j_data, 32'hB);
`else
        chk("byp.j_ready_same_cycle", 32'(query_j_ready), 32'd0);
`endif
        chk("byp.k_ready_unwritten", 32'(query_k_ready), 32'd0);
        step();
        idle_inputs();
        query_j_index = 3'd4; query_k_index = 3'd6;
        #1;
        chk("byp.j_ready_stored", 32'(query_j_ready), 32'd1);
        chk("byp.j_data_lsb_wins", query_j_data, 32'hB);
        chk("byp.k_ready_not_busy", 32'(query_k_ready), 32'd0);

        // Reset while the flush clear is still pending
        do_reset();
        alloc(ROB_JALR, 5'd3, 32'h80);
        RS_update_en = 1'b1; RS_update_index = 3'd0; RS_update_data = 32'h300;
        step();
        idle_inputs();
        step();
        chk("rstfl.flush_before", 32'(flush_signal), 32'd1);
        chk("rstfl.commit_data_before", commit_data, 32'h84);
        rst_in = 1'b1;
        alloc_en = 1'b1; alloc_rd = 5'd7;
        step();
        rst_in = 1'b0;
        idle_inputs();
        chk("rstfl.flush_signal", 32'(flush_signal), 32'd0);
        chk("rstfl.commit_en", 32'(commit_en), 32'd0);
        chk("rstfl.commit_rd", 32'(commit_rd), 32'd0);
        chk("rstfl.commit_data", commit_data, 32'd0);
        chk("rstfl.flush_pc", flush_pc, 32'd0);
        chk("rstfl.isEmpty", 32'(isEmpty), 32'd1);
        chk("rstfl.alloc_robEntry", 32'(alloc_robEntry), 32'd0);
        step();
        chk("rstfl.flush_stays_low", 32'(flush_signal), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/reorder_buffer.md
# reorder_buffer

Circular reorder buffer between the dispatcher and the register file. It allocates one entry per dispatched instruction and captures results broadcast by the reservation station and the load/store buffer. It retires entries strictly in program order and redirects the front end by flushing the whole backend on branch misprediction or `jalr`. It also serves combinational operand lookups, so the dispatcher can resolve `Qj`/`Qk` tags that are already complete.

## Interface
- `RoB_WIDTH`, default 3: log2 of entry count.
- `RoB_SIZE`, default `1 << RoB_WIDTH`: number of entries.
- `NON_DEP`, default `1 << RoB_WIDTH`: "no dependency" tag value.
- `clk_in` in, 1: clock. All state updates on the rising edge.
- `rst_in` in, 1: reset, synchronous, active-high.
- `rdy_in` in, 1: when low, all state and outputs hold.
- `alloc_en` in, 1: allocate an entry this cycle.
- `alloc_type` in, 2: `ROB_REG`, `ROB_BRANCH`, `ROB_JALR` or `ROB_STORE`.
- `alloc_rd` in, 5: destination register.
- `alloc_pc` in, 32: instruction pc.
- `alloc_pred_taken` in, 1: front-end branch prediction.
- `alloc_target` in, 32: branch taken-target.
- `alloc_robEntry` out, `RoB_WIDTH`: tag that the next allocation receives (current tail). Combinational.
- `RS_update_en`/`RS_update_index`/`RS_update_data` in, 1/`RoB_WIDTH`/32: ALU writeback from the reservation station.
- `LSB_update_en`/`LSB_update_index`/`LSB_update_data` in, 1/`RoB_WIDTH`/32: load result or store-ready writeback.
- `query_j_index`, `query_k_index` in, `RoB_WIDTH`: operand lookup tags.
- `query_j_ready`/`query_j_data`, `query_k_ready`/`query_k_data` out, 1/32: lookup result. Combinational.
- `commit_en`/`commit_rd`/`commit_data`/`commit_robEntry` out, 1/5/32/`RoB_WIDTH`: register-file retirement. Registered.
- `commit_store_en`/`commit_store_robEntry` out, 1/`RoB_WIDTH`: tells the LSB to perform the store. Registered.
- `flush_signal`/`flush_pc` out, 1/32: backend flush and front-end redirect. Registered.
- `isFull`, `isEmpty` out, 1: occupancy status.

## Operation
- State:
  - Per entry: `busy`, `ready`, `type`, `rd`, `pc`, `pred_taken`, `target`, `data`.
  - Buffer: `head`, `tail` (`RoB_WIDTH` bits, natural wrap) and `count` (`RoB_WIDTH+1` bits).
  - `isFull = (count == RoB_SIZE)`, `isEmpty = (count == 0)`.
- Allocate when `alloc_en && !isFull`:
  - Write the entry at `tail`, set `busy=1`, `ready=0`, then advance `tail`.
  - `alloc_en` while full is ignored, even if a commit frees an entry in the same cycle.
- Writeback:
  - Each enabled port sets `ready=1` and `data` at its index, provided the entry is busy.
  - If both ports target the same index, the LSB port wins.
- Commit when the head entry is `busy && ready` (registered `ready`), at most one per cycle:
  - `ROB_REG`: `commit_en=1`, `commit_rd=rd`, `commit_data=data`. `rd==0` is still emitted; the register file discards it.
  - `ROB_STORE`: `commit_store_en=1`. No register write.
  - `ROB_BRANCH`: `data[0]` is the actual taken flag. If it differs from `pred_taken`, assert flush with `flush_pc = taken ? target : pc+4`. No register write.
  - `ROB_JALR`: commit `rd` with `pc+4`, and always flush with `flush_pc = data`.
  - After a commit, clear the entry and advance `head`.
- Flush:
  - The cycle after `flush_signal` is registered high, all entries are cleared and `head=tail=count=0`.
  - Allocations and writebacks presented in that cycle are discarded.
  - No further commit occurs until the buffer has been refilled.
- Count: allocate and commit in the same cycle leave `count` unchanged.
- Query: `query_x_ready = busy[idx] && ready[idx]` and `query_x_data = data[idx]`. A non-busy index returns `ready=0`.

## Timing
- Reset: all entries cleared; `head=tail=count=0`; `commit_en`, `commit_store_en` and `flush_signal` = 0; `commit_rd`, `commit_data`, `commit_robEntry` and `flush_pc` = 0; `isEmpty=1`, `isFull=0`.
- Reset mid-operation overrides every event in that cycle, including a pending flush.
- Allocation:
  - An entry allocated in cycle N is visible to writeback from cycle N+1.
  - Earliest commit is cycle N+2, the edge after its writeback at N+1.
- Writeback-to-commit: a writeback in cycle N is eligible for commit at N+1, and the commit outputs are valid at N+2.
- Pulses: `commit_*` and `flush_signal` are one-cycle pulses, deasserted by default every active cycle.
- Flush timing:
  - The flush-causing commit and `flush_signal` are registered on the same edge.
  - The clear takes effect on the following edge.
  - `rdy_in` low delays every step.

## Configuration
- `ROB_BYPASS_EN` defined: the query ports also match the same-cycle `RS_update_*` and `LSB_update_*` ports, returning `ready=1` with the broadcast data; the LSB port has priority.
- `ROB_BYPASS_EN` undefined: queries see only stored state, so a result broadcast in cycle N becomes visible at N+1.

## Structure
- Package `rob_pkg`: type codes `ROB_REG=0`, `ROB_BRANCH=1`, `ROB_JALR=2`, `ROB_STORE=3`, and the `NON_DEP` constant shared with the reservation station and dispatcher.
- Sub-module `rob_query_port`: stored lookup plus optional bypass. Instantiated twice, once for j and once for k.

## Test plan
- Reset, then allocate three `ROB_REG` entries (rd=1,2,3). Write back out of order: index 2 = 0x30, index 0 = 0x10, index 1 = 0x20. Commits must appear in order rd=1/0x10, 2/0x20, 3/0x30 on consecutive cycles, followed by `isEmpty=1`.
- Fill all 8 entries so `isFull=1`. Present `alloc_en` with a commit in the same cycle: the allocation is ignored. Then run 20 further alloc/commit pairs to verify that `tail` and `head` wrap.
- Allocate a `ROB_BRANCH` with `pred_taken=0`, `target=0x100`, `pc=0x40`, and write back data=1: `flush_signal=1` with `flush_pc=0x100`. On the next cycle `count=0`.
- Allocate a `ROB_JALR` with `pc=0x80`, `rd=1`, and write back 0x200: commit rd=1, data=0x84, `flush_pc=0x200`.
- Drive RS and LSB writebacks to index 4 in the same cycle with 0xA and 0xB: the stored data is 0xB. Query index 4 in that cycle: `ready=1`, data 0xB with `ROB_BYPASS_EN` defined; `ready=0` without it.
- Assert `rst_in` while a flush is pending: all outputs go to 0 and `flush_signal` stays 0.
